// File: rtl/bpm_pkg.sv
// Shared constants, state encoding and BPM range helpers for the BPM beat generator.
`timescale 1ns/1ps
package bpm_pkg;

  localparam int unsigned INTERVAL_W = 32;
  localparam int unsigned BPM_W      = 8;

  localparam logic [INTERVAL_W-1:0] TICKS_PER_MINUTE = 32'd6000000;
  localparam logic [BPM_W-1:0]      MIN_BPM          = 8'd30;
  localparam logic [BPM_W-1:0]      MAX_BPM          = 8'd254;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bpm_state_e;

  function automatic logic bpm_in_range(input logic [BPM_W-1:0] b);
    return (b >= MIN_BPM) && (b <= MAX_BPM);
  endfunction

  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] b);
    if (b < MIN_BPM) return MIN_BPM;
    if (b > MAX_BPM) return MAX_BPM;
    return b;
  endfunction

endpackage

// File: rtl/bpm_beat_generator_divider.sv
// Serial restoring divider: TICKS_PER_MINUTE / divisor, one quotient bit per clock.
// A start while busy abandons the current divide and begins again with the new divisor.
`timescale 1ns/1ps
module bpm_divider
  import bpm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BPM_W-1:0]      divisor,
  output logic                  busy,
  output logic                  done,
  output logic [INTERVAL_W-1:0] quotient,
  output logic [BPM_W-1:0]      divisor_q
);

  logic [BPM_W-1:0] rem_q;
  logic [4:0]       cnt_q;
  logic [BPM_W:0]   rem_sh;
  logic [BPM_W:0]   rem_sub;
  logic             q_bit;

  // The dividend shifts out of the top of quotient while quotient bits shift in below.
  always_comb begin
    rem_sh  = {rem_q, quotient[INTERVAL_W-1]};
    rem_sub = rem_sh - {1'b0, divisor_q};
    q_bit   = (rem_sh >= {1'b0, divisor_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quotient  <= '0;
      divisor_q <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quotient  <= TICKS_PER_MINUTE;
      divisor_q <= divisor;
    end else if (busy && done) begin
      // Result is held for exactly one cycle so the top can publish it.
      busy <= 1'b0;
      done <= 1'b0;
    end else if (busy) begin
      quotient <= {quotient[INTERVAL_W-2:0], q_bit};
      rem_q    <= q_bit ? rem_sub[BPM_W-1:0] : rem_sh[BPM_W-1:0];
      cnt_q    <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) done <= 1'b1;
    end
  end

endmodule

// File: rtl/bpm_beat_generator.sv
// Converts a BPM request into a beat interval and emits a one-cycle beat every interval ticks.
// Optional BPM_GEN_SYNC_EN adds a beat_sync input that realigns the beat phase.
`timescale 1ns/1ps
module bpm_beat_generator
  import bpm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_en,
  input  logic [BPM_W-1:0]      bpm_in,
  input  logic                  bpm_load,
  input  logic [BPM_W-1:0]      default_bpm,
`ifdef BPM_GEN_SYNC_EN
  input  logic                  beat_sync,
`endif
  output logic                  busy,
  output logic [INTERVAL_W-1:0] interval,
  output logic [BPM_W-1:0]      active_bpm,
  output logic                  beat
);

  bpm_state_e            state_q, state_d;
  logic [INTERVAL_W-1:0] phase_q, phase_d;
  logic                  beat_d;
  logic                  wrap;
  logic                  init_q;
  logic                  div_start;
  logic [BPM_W-1:0]      div_bpm;
  logic                  div_busy;
  logic                  div_done;
  logic [INTERVAL_W-1:0] div_quotient;
  logic [BPM_W-1:0]      div_divisor;
  logic                  publish;

  // init_q fires one automatic divide with default_bpm on the first cycle out of reset.
  assign div_start = bpm_load | init_q;
  assign div_bpm   = (bpm_load && bpm_in_range(bpm_in)) ? bpm_in : clamp_bpm(default_bpm);
  assign publish   = div_done && !div_start;
  assign busy      = div_busy;

  bpm_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .divisor   (div_bpm),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .divisor_q (div_divisor)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    beat_d  = 1'b0;
    wrap    = 1'b0;
    if (state_q == RUN) begin
      wrap = tick_en && (phase_q == (interval - 32'd1));
      if (tick_en) phase_d = wrap ? '0 : phase_q + 32'd1;
      if (wrap) beat_d = 1'b1;
`ifdef BPM_GEN_SYNC_EN
      if (beat_sync) begin
        phase_d = '0;
        beat_d  = 1'b1;
      end
`endif
    end
    // A completing divide restarts the phase; a wrap in the same cycle still beats.
    if (publish) begin
      state_d = RUN;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      beat       <= 1'b0;
      init_q     <= 1'b1;
      interval   <= '0;
      active_bpm <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beat    <= beat_d;
      init_q  <= 1'b0;
      if (publish) begin
        interval   <= div_quotient;
        active_bpm <= div_divisor;
      end
    end
  end

endmodule

// File: doc/bpm_beat_generator.md
# bpm_beat_generator

Converts a tempo in BPM back into a beat interval and emits a periodic one-cycle beat pulse. Inverse of the interval-to-BPM path: the BPM value is turned into a tick count (TICKS_PER_MINUTE / bpm) by a serial divider, and a phase counter clocked by the sample-rate tick enable generates beats. It sits in AudioController between the tempo select logic (detected or user BPM) and the beat-synchronised effects/LED logic.

## Interface
- TICKS_PER_MINUTE, 6000000, tick_en pulses per minute (100 kHz tick)
- MIN_BPM, 30, lowest accepted BPM
- MAX_BPM, 254, highest accepted BPM
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_en  in  1  one-cycle count enable, 100 kHz
- bpm_in  in  8  requested tempo, sampled when bpm_load=1
- bpm_load  in  1  one-cycle request to adopt bpm_in
- default_bpm  in  8  tempo used after reset and when bpm_in is out of range
- beat_sync  in  1  phase realign pulse (present only with BPM_GEN_SYNC_EN)
- busy  out  1  divider running
- interval  out  32  active beat interval in ticks
- active_bpm  out  8  tempo the active interval was computed from
- beat  out  1  one-cycle beat pulse

## Operation
- Reset: busy=0, interval=0, active_bpm=0, beat=0, phase counter=0, state IDLE.
- Out-of-range request (bpm_in < MIN_BPM or > MAX_BPM, incl. 0) is replaced by default_bpm; default_bpm itself is clamped to [MIN_BPM, MAX_BPM].
- States: IDLE (no valid interval, beat never asserted), RUN (beating).
- First cycle after reset release: divider started with default_bpm automatically.
- Divider: restoring, unsigned, 32-bit dividend TICKS_PER_MINUTE, 8-bit divisor, one quotient bit per clock; result = floor(TICKS_PER_MINUTE / bpm). Examples: 120 -> 50000, 60 -> 100000, 254 -> 23622, 30 -> 200000.
- On divide completion: interval and active_bpm updated in the same cycle, phase counter cleared, state -> RUN.
- RUN: phase counter increments on tick_en; on the tick_en where counter == interval-1, counter -> 0 and beat=1 in the following cycle. Beat period = interval ticks exactly.
- Beats continue at the old interval while a new divide is in progress.
- bpm_load while busy: divider restarts with the new value (latest wins); no result from the abandoned divide is published.
- bpm_load and tick_en in the same cycle: both handled independently.
- Completion and counter wrap in the same cycle: new interval adopted, counter cleared, beat from the wrap still issued.

## Timing
- bpm_load at cycle N: busy=1 from N+1; interval/active_bpm valid and busy=0 at N+34 (1 load + 32 iterations + 1 publish).
- Reset release to first valid interval: 34 cycles.
- beat: registered, exactly 1 clk wide, 1 cycle after the qualifying tick_en.
- rst_n asserted mid-divide or mid-beat: all outputs to reset values immediately (asynchronous); no partial result survives.

## Configuration
- BPM_GEN_SYNC_EN defined: beat_sync port present; beat_sync=1 in RUN clears the phase counter and forces beat=1 next cycle (realign to detected beat); if it coincides with a wrap only one beat is issued; ignored in IDLE.
- Not defined: port absent, phase is free-running from the last interval update.

## Structure
- Shared package bpm_pkg: TICKS_PER_MINUTE, MIN_BPM, MAX_BPM, state encoding (IDLE, RUN), interval width (32).
- Sub-module bpm_divider: serial restoring divider with start/busy/done and 32-bit quotient; restart on start while busy.

## Test plan
- Reset with default_bpm=120 -> after 34 cycles interval=50000, active_bpm=120; first beat 50000 tick_en pulses later, then every 50000.
- bpm_load with bpm_in=254 -> interval=23622 at N+34; busy high for cycles N+1..N+33.
- bpm_in=0 and bpm_in=255 with default_bpm=90 -> interval=66666, active_bpm=90; default_bpm=10 -> clamped, interval=200000.
- bpm_load=60 then bpm_load=200 five cycles later -> only interval=30000 published, 34 cycles after second load; beats continue at old period meanwhile.
- rst_n pulsed low mid-divide and mid-RUN -> all outputs 0 at once, fresh default divide after release.
- BPM_GEN_SYNC_EN: beat_sync at tick 1000 of a 50000 interval -> beat next cycle, next beat 50000 ticks later.
